// File: rtl/instr_mem_bank_arbiter_pkg.sv
// rtl/instr_mem_bank_arbiter_pkg.sv - shared sizes and address helpers for the bank arbiter
package instr_mem_pkg;

   localparam int NUM_CPUS           = 3;
   localparam int NUM_BANKS          = 3;
   localparam int SIZE_BANKI         = 32;
   localparam int INSTR_W            = 32;
   localparam int SHIRINA_BANKI      = $clog2(SIZE_BANKI);
   localparam int SHIRINA_VSEH_BANOK = $clog2(SIZE_BANKI * NUM_BANKS);
   localparam int BANK_W             = SHIRINA_VSEH_BANOK - SHIRINA_BANKI;

   // Upper address bits select the bank; may exceed NUM_BANKS-1 for out-of-range fetches.
   function automatic logic [BANK_W-1:0] bank_of(input logic [SHIRINA_VSEH_BANOK-1:0] adr);
      return adr[SHIRINA_VSEH_BANOK-1:SHIRINA_BANKI];
   endfunction

endpackage

// File: rtl/instr_mem_bank_arbiter_if.sv
// rtl/instr_mem_bank_arbiter_if.sv - CPU fetch ports and memory bank ports of the arbiter
interface instr_mem_bank_arbiter_if import instr_mem_pkg::*; ();

   logic [NUM_CPUS-1:0]                              req_vld;
   logic [NUM_CPUS-1:0][SHIRINA_VSEH_BANOK-1:0]      req_adr;
   logic [NUM_CPUS-1:0]                              req_rdy;
   logic [NUM_CPUS-1:0]                              rsp_vld;
   logic [NUM_CPUS-1:0][INSTR_W-1:0]                 rsp_data;
   logic [NUM_CPUS-1:0]                              rsp_err;
   logic [NUM_BANKS-1:0]                             bank_re;
   logic [NUM_BANKS-1:0][SHIRINA_BANKI-1:0]          bank_ra;
   logic [NUM_BANKS-1:0][INSTR_W-1:0]                bank_rd;

   // Arbiter side
   modport slave (
      input  req_vld, req_adr, bank_rd,
      output req_rdy, rsp_vld, rsp_data, rsp_err, bank_re, bank_ra
   );

   // CPU / memory side
   modport master (
      output req_vld, req_adr, bank_rd,
      input  req_rdy, rsp_vld, rsp_data, rsp_err, bank_re, bank_ra
   );

endinterface

// File: rtl/instr_mem_bank_arbiter_rr_arbiter.sv
// rtl/instr_mem_bank_arbiter_rr_arbiter.sv - round-robin arbiter with its own priority pointer
module rr_arbiter #(
   parameter int N = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] req,
   output logic [N-1:0] gnt,
   output logic         gnt_vld
);

   localparam int PW = (N > 1) ? $clog2(N) : 1;

   logic [PW-1:0] ptr;
   logic [PW-1:0] ptr_nxt;

   // Scan from ptr upward modulo N; the first requester wins and the pointer moves past it.
   always_comb begin
      int idx;
      gnt     = '0;
      gnt_vld = 1'b0;
      ptr_nxt = ptr;
      idx     = 0;
      for (int i = 0; i < N; i++) begin
         idx = int'(ptr) + i;
         if (idx >= N) idx = idx - N;
         if (!gnt_vld && req[idx]) begin
            gnt[idx] = 1'b1;
            gnt_vld  = 1'b1;
            ptr_nxt  = (idx == N - 1) ? '0 : PW'(idx + 1);
         end
      end
   end

   // Pointer register; holds when nothing is granted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) ptr <= '0;
      else     ptr <= ptr_nxt;
   end

endmodule

// File: rtl/instr_mem_bank_arbiter.sv
// rtl/instr_mem_bank_arbiter.sv - per-bank round-robin fetch arbiter with one-cycle response routing
module instr_mem_bank_arbiter import instr_mem_pkg::*; (
   input  logic                     clk,
   input  logic                     rst,
   instr_mem_bank_arbiter_if.slave  bus
);

   logic [NUM_CPUS-1:0][BANK_W-1:0]   bank_idx;
   logic [NUM_CPUS-1:0]               oor;
   logic [NUM_BANKS-1:0][NUM_CPUS-1:0] cand;
   logic [NUM_BANKS-1:0][NUM_CPUS-1:0] gnt;
   logic [NUM_BANKS-1:0]              gnt_vld;

   logic [NUM_CPUS-1:0]               rdy;
   logic [NUM_BANKS-1:0][SHIRINA_BANKI-1:0] ra;

   logic [NUM_CPUS-1:0]               rsp_pend;
   logic [NUM_CPUS-1:0]               rsp_oor;
   logic [NUM_CPUS-1:0][BANK_W-1:0]   rsp_bank;
   logic [NUM_CPUS-1:0][INSTR_W-1:0]  data;

   // Split addresses and build per-bank candidate masks; reset masks every request.
   always_comb begin
      bank_idx = '0;
      oor      = '0;
      cand     = '0;
      for (int c = 0; c < NUM_CPUS; c++) begin
         bank_idx[c] = bank_of(bus.req_adr[c]);
         oor[c]      = bus.req_vld[c] & ~rst & (int'(bank_idx[c]) >= NUM_BANKS);
         for (int b = 0; b < NUM_BANKS; b++) begin
            cand[b][c] = bus.req_vld[c] & ~rst & (int'(bank_idx[c]) == b);
         end
      end
   end

   for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      rr_arbiter #(.N(NUM_CPUS)) u_arb (
         .clk     (clk),
         .rst     (rst),
         .req     (cand[b]),
         .gnt     (gnt[b]),
         .gnt_vld (gnt_vld[b])
      );
   end

   // Collapse bank grants into per-CPU ready and drive each bank with its winner's address.
   always_comb begin
      rdy = oor;
      ra  = '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
         for (int c = 0; c < NUM_CPUS; c++) begin
            if (gnt[b][c]) begin
               rdy[c] = 1'b1;
               ra[b]  = bus.req_adr[c][SHIRINA_BANKI-1:0];
            end
         end
      end
   end

   // Remember which bank (or error) each accepted request will be answered from next cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_pend <= '0;
         rsp_oor  <= '0;
         rsp_bank <= '0;
      end else begin
         rsp_pend <= rdy;
         rsp_oor  <= oor;
         rsp_bank <= bank_idx;
      end
   end

   // Route bank read data back to the CPU that owns the pending response.
   always_comb begin
      data = '0;
      for (int c = 0; c < NUM_CPUS; c++) begin
         if (rsp_pend[c] && !rsp_oor[c]) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
               if (int'(rsp_bank[c]) == b) data[c] = bus.bank_rd[b];
            end
         end
      end
   end

   assign bus.req_rdy  = rdy;
   assign bus.bank_re  = gnt_vld;
   assign bus.bank_ra  = ra;
   assign bus.rsp_vld  = rsp_pend;
   assign bus.rsp_err  = rsp_pend & rsp_oor;
   assign bus.rsp_data = data;

endmodule

// File: tb/tb_instr_mem_bank_arbiter.sv
// tb/tb_instr_mem_bank_arbiter.sv - scoreboard bench for the instruction memory bank arbiter
module tb_instr_mem_bank_arbiter;
   import instr_mem_pkg::*;

   typedef struct {
      logic [INSTR_W-1:0] data;
      logic               err;
      int                 due;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   vectors = 0;
   int   miscompares = 0;
   int   cyc = 0;
   exp_t sb [NUM_CPUS][$];

   always #5 clk = ~clk;

   instr_mem_bank_arbiter_if bus ();

   instr_mem_bank_arbiter dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   function automatic logic [INSTR_W-1:0] word_at(input int b, input int ra);
      return 32'hC000_5A00 | 32'(b << 16) | 32'(ra);
   endfunction

   // Synchronous-read bank model: data appears the cycle after bank_re.
   always @(posedge clk) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
         if (bus.bank_re[b]) bus.bank_rd[b] <= word_at(b, int'(bus.bank_ra[b]));
      end
   end

   task automatic check_bits(input string name, input logic [63:0] got, input logic [63:0] want);
      vectors++;
      if (got !== want) begin
         miscompares++;
         $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, got, want);
      end
   endtask

   task automatic drive_check(input logic [2:0] vld, input int a0, input int a1, input int a2,
                              input logic [2:0] e_rdy, input logic [2:0] e_re,
                              input int r0, input int r1, input int r2, input bit push);
      int adr [NUM_CPUS];
      exp_t e;
      adr[0] = a0; adr[1] = a1; adr[2] = a2;
      bus.req_vld = vld;
      for (int c = 0; c < NUM_CPUS; c++) bus.req_adr[c] = 7'(adr[c]);
      #1;
      check_bits("req_rdy", 64'(bus.req_rdy), 64'(e_rdy));
      check_bits("bank_re", 64'(bus.bank_re), 64'(e_re));
      check_bits("bank_ra", 64'(bus.bank_ra), 64'({5'(r2), 5'(r1), 5'(r0)}));
      if (push) begin
         for (int c = 0; c < NUM_CPUS; c++) begin
            if (e_rdy[c]) begin
               e.err  = (adr[c] >= 96);
               e.data = e.err ? '0 : word_at(adr[c] / 32, adr[c] % 32);
               e.due  = cyc + 1;
               sb[c].push_back(e);
            end
         end
      end
   endtask

   task automatic apply(input logic [2:0] vld, input int a0, input int a1, input int a2,
                        input logic [2:0] e_rdy, input logic [2:0] e_re,
                        input int r0, input int r1, input int r2, input bit push = 1'b1);
      @(negedge clk);
      drive_check(vld, a0, a1, a2, e_rdy, e_re, r0, r1, r2, push);
   endtask

   // Response monitor: every rsp_vld must match the oldest expectation and arrive on its due cycle.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         cyc++;
         #1;
         for (int c = 0; c < NUM_CPUS; c++) begin
            if (bus.rsp_vld[c]) begin
               if (sb[c].size() == 0) begin
                  check_bits($sformatf("unexpected_rsp%0d", c), 64'd1, 64'd0);
               end else begin
                  e = sb[c].pop_front();
                  check_bits($sformatf("rsp_data%0d", c), 64'(bus.rsp_data[c]), 64'(e.data));
                  check_bits($sformatf("rsp_err%0d", c), 64'(bus.rsp_err[c]), 64'(e.err));
                  check_bits($sformatf("rsp_cycle%0d", c), 64'(cyc), 64'(e.due));
               end
            end else begin
               check_bits($sformatf("rsp_err_idle%0d", c), 64'(bus.rsp_err[c]), 64'd0);
               if (sb[c].size() > 0 && sb[c][0].due <= cyc) begin
                  e = sb[c].pop_front();
                  check_bits($sformatf("missing_rsp%0d", c), 64'd0, 64'd1);
               end
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      bus.req_vld = 3'b111;
      for (int c = 0; c < NUM_CPUS; c++) bus.req_adr[c] = 7'd3;
      repeat (2) @(negedge clk);
      #1;
      check_bits("rst_req_rdy", 64'(bus.req_rdy), 64'd0);
      check_bits("rst_bank_re", 64'(bus.bank_re), 64'd0);
      check_bits("rst_rsp_vld", 64'(bus.rsp_vld), 64'd0);
      check_bits("rst_rsp_err", 64'(bus.rsp_err), 64'd0);
      check_bits("rst_rsp_data", 64'(bus.rsp_data), 64'd0);

      // All CPUs hammer bank 0 from reset release: strict rotation 0,1,2,0,1,2.
      @(negedge clk);
      rst = 1'b0;
      drive_check(3'b111, 3, 3, 3, 3'b001, 3'b001, 3, 0, 0, 1'b1);
      apply(3'b111, 3, 3, 3, 3'b010, 3'b001, 3, 0, 0);
      apply(3'b111, 3, 3, 3, 3'b100, 3'b001, 3, 0, 0);
      apply(3'b111, 3, 3, 3, 3'b001, 3'b001, 3, 0, 0);
      apply(3'b111, 3, 3, 3, 3'b010, 3'b001, 3, 0, 0);
      apply(3'b111, 3, 3, 3, 3'b100, 3'b001, 3, 0, 0);

      // One CPU per bank: all granted in parallel.
      apply(3'b111, 5, 40, 70, 3'b111, 3'b111, 5, 8, 6);

      // Bank 1 pointer now 2: CPU0 wins, then CPU1, then CPU0's retry.
      apply(3'b011, 33, 34, 0, 3'b001, 3'b010, 0, 1, 0);
      apply(3'b011, 35, 34, 0, 3'b010, 3'b010, 0, 2, 0);
      apply(3'b001, 35, 0, 0, 3'b001, 3'b010, 0, 3, 0);

      // Out-of-range accepted without touching any bank; 95 is the last valid word.
      apply(3'b010, 0, 100, 0, 3'b010, 3'b000, 0, 0, 0);
      apply(3'b111, 96, 95, 127, 3'b111, 3'b100, 0, 0, 31);

      // Uncontested back-to-back stream.
      apply(3'b001, 0, 0, 0, 3'b001, 3'b001, 0, 0, 0);
      apply(3'b001, 1, 0, 0, 3'b001, 3'b001, 1, 0, 0);
      apply(3'b001, 2, 0, 0, 3'b001, 3'b001, 2, 0, 0);
      apply(3'b001, 3, 0, 0, 3'b001, 3'b001, 3, 0, 0);

      // Grant, then reset before the capturing edge: the response is dropped.
      apply(3'b010, 0, 10, 0, 3'b010, 3'b001, 10, 0, 0, 1'b0);
      #2;
      rst = 1'b1;
      @(negedge clk);
      #1;
      check_bits("mid_rst_req_rdy", 64'(bus.req_rdy), 64'd0);
      check_bits("mid_rst_bank_re", 64'(bus.bank_re), 64'd0);
      check_bits("mid_rst_rsp_vld", 64'(bus.rsp_vld), 64'd0);
      bus.req_vld = 3'b000;
      @(negedge clk);
      rst = 1'b0;

      // Pointers back at 0 in banks 0 and 1.
      apply(3'b111, 3, 4, 5, 3'b001, 3'b001, 3, 0, 0);
      apply(3'b111, 33, 33, 33, 3'b001, 3'b010, 0, 1, 0);

      @(negedge clk);
      bus.req_vld = 3'b000;
      repeat (3) @(negedge clk);
      for (int c = 0; c < NUM_CPUS; c++) begin
         check_bits($sformatf("drain%0d", c), 64'(sb[c].size()), 64'd0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
